// File: rtl/mdu_divider_pkg.sv
// Shared definitions for the MDU iterative divider: controller state encoding.
package mdu_divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ITER = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } div_state_t;

endpackage

// File: rtl/adderc.sv
// Ripple-style W-bit adder with carry in and carry out.
module adderc #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout
);

  assign {cout, s} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};

endmodule

// File: rtl/inc.sv
// W-bit incrementer; fed an inverted operand it forms the two's complement negation.
module inc #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  output logic [W-1:0] y
);

  assign y = a + W'(1);

endmodule

// File: rtl/mdu_divider.sv
// Multicycle restoring divider for DIV/DIVU; one quotient bit per clock, HI/LO
// results held until the next accepted start.
module mdu_divider
  import mdu_divider_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNTW  = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic             cancel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quo,
  output logic [WIDTH-1:0] rem,
  output logic             divzero
);

  div_state_t state, state_next;

  logic [WIDTH-1:0] r, q, bm, a_raw;
  logic [CNTW-1:0]  count;
  logic             sign_q, sign_r, divzero_next;

  logic [WIDTH-1:0] a_neg, b_neg, q_neg, r_neg, a_abs, b_abs;
  logic [WIDTH:0]   r_sh, trial;
  logic             no_borrow, trial_unused;
  logic             accept;

  // Cancel wins over a simultaneous start.
  assign accept = ((state == IDLE) || (state == DONE)) && start && !cancel;

  inc #(.W(WIDTH)) u_neg_a (.a(~a), .y(a_neg));
  inc #(.W(WIDTH)) u_neg_b (.a(~b), .y(b_neg));
  inc #(.W(WIDTH)) u_neg_q (.a(~q), .y(q_neg));
  inc #(.W(WIDTH)) u_neg_r (.a(~r), .y(r_neg));

  assign a_abs = (is_signed && a[WIDTH-1]) ? a_neg : a;
  assign b_abs = (is_signed && b[WIDTH-1]) ? b_neg : b;

  // {r,q} shifted left; the extra top bit keeps r_sh - |b| exact.
  assign r_sh = {r, q[WIDTH-1]};

  adderc #(.W(WIDTH+1)) u_trial (
    .a   (r_sh),
    .b   (~{1'b0, bm}),
    .cin (1'b1),
    .s   (trial),
    .cout(no_borrow)
  );

  // The remainder always fits WIDTH bits after a successful subtract.
  assign trial_unused = trial[WIDTH];

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (accept) state_next = ITER;
      ITER: begin
        if (cancel)                  state_next = IDLE;
        else if (count == CNTW'(1))  state_next = FIX;
      end
      FIX:  state_next = cancel ? IDLE : DONE;
      DONE: state_next = accept ? ITER : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == ITER) || (state == FIX);
    done = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r            <= '0;
      q            <= '0;
      bm           <= '0;
      a_raw        <= '0;
      count        <= '0;
      sign_q       <= 1'b0;
      sign_r       <= 1'b0;
      divzero_next <= 1'b0;
      quo          <= '0;
      rem          <= '0;
      divzero      <= 1'b0;
    end else begin
      if (accept) begin
        r            <= '0;
        q            <= a_abs;
        bm           <= b_abs;
        a_raw        <= a;
        count        <= CNTW'(WIDTH);
        sign_q       <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
        sign_r       <= is_signed & a[WIDTH-1];
        divzero_next <= (b == '0);
      end else if (state == ITER) begin
        r     <= no_borrow ? trial[WIDTH-1:0] : r_sh[WIDTH-1:0];
        q     <= {q[WIDTH-2:0], no_borrow};
        count <= count - CNTW'(1);
      end

      if ((state == FIX) && !cancel) begin
        if (divzero_next) begin
          quo     <= '1;
          rem     <= a_raw;
          divzero <= 1'b1;
        end else begin
          quo     <= sign_q ? q_neg : q;
          rem     <= sign_r ? r_neg : r;
          divzero <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_mdu_divider.sv
// Directed self-checking bench for mdu_divider: vector table plus handshake/abort sequences.
module tb_mdu_divider;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        is_signed = 1'b0;
  logic        cancel = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy, done, divzero;
  logic [31:0] quo, rem;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mdu_divider #(.WIDTH(32), .CNTW(6)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .is_signed(is_signed),
    .cancel   (cancel),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .quo      (quo),
    .rem      (rem),
    .divzero  (divzero)
  );

  typedef struct {
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic launch(input logic sgn, input logic [31:0] av, input logic [31:0] bv);
    @(negedge clk);
    start = 1'b1; is_signed = sgn; a = av; b = bv;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Waits (bounded) for done; lat counts clock edges from the call point.
  task automatic wait_done(output int lat, output int bcnt);
    lat = 0; bcnt = 0;
    while (!done && lat < 200) begin
      if (busy) bcnt++;
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    int lat, bcnt, ndone;

    vecs[0] = '{1'b0, 32'd100,       32'd7,         32'd14,        32'd2,         1'b0};
    vecs[1] = '{1'b1, 32'hFFFFFFF9,  32'd2,         32'hFFFFFFFD,  32'hFFFFFFFF,  1'b0};
    vecs[2] = '{1'b1, 32'd7,         32'hFFFFFFFE,  32'hFFFFFFFD,  32'd1,         1'b0};
    vecs[3] = '{1'b1, 32'h80000000,  32'hFFFFFFFF,  32'h80000000,  32'd0,         1'b0};
    vecs[4] = '{1'b0, 32'hFFFFFFFF,  32'd1,         32'hFFFFFFFF,  32'd0,         1'b0};
    vecs[5] = '{1'b0, 32'h1234,      32'd0,         32'hFFFFFFFF,  32'h1234,      1'b1};
    vecs[6] = '{1'b1, 32'hFFFFFFF0,  32'd0,         32'hFFFFFFFF,  32'hFFFFFFF0,  1'b1};
    vecs[7] = '{1'b1, 32'hFFFFFF9C,  32'd7,         32'hFFFFFFF2,  32'hFFFFFFFE,  1'b0};
    vecs[8] = '{1'b0, 32'h80000000,  32'hFFFFFFFF,  32'd0,         32'h80000000,  1'b0};

    repeat (2) @(negedge clk);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_quo", quo, 32'd0);
    check("reset_rem", rem, 32'd0);
    check("reset_divzero", {31'd0, divzero}, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 9; i++) begin
      launch(vecs[i].sgn, vecs[i].a, vecs[i].b);
      wait_done(lat, bcnt);
      check($sformatf("v%0d_latency", i), lat, 32'd33);
      check($sformatf("v%0d_busy_cycles", i), bcnt, 32'd33);
      check($sformatf("v%0d_quo", i), quo, vecs[i].q);
      check($sformatf("v%0d_rem", i), rem, vecs[i].r);
      check($sformatf("v%0d_divzero", i), {31'd0, divzero}, {31'd0, vecs[i].dz});
      @(negedge clk);
      check($sformatf("v%0d_done_pulse", i), {31'd0, done}, 32'd0);
    end

    // Second start during the operation must be ignored.
    launch(1'b0, 32'd100, 32'd7);
    repeat (4) @(negedge clk);
    start = 1'b1; is_signed = 1'b0; a = 32'd50; b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat, bcnt);
    check("ign_latency", lat, 32'd28);
    check("ign_quo", quo, 32'd14);
    check("ign_rem", rem, 32'd2);

    // Start in the DONE cycle launches back-to-back.
    start = 1'b1; is_signed = 1'b1; a = 32'hFFFFFF9C; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    check("b2b_busy", {31'd0, busy}, 32'd1);
    check("b2b_done_low", {31'd0, done}, 32'd0);
    wait_done(lat, bcnt);
    check("b2b_latency", lat, 32'd33);
    check("b2b_quo", quo, 32'hFFFFFFF2);
    check("b2b_rem", rem, 32'hFFFFFFFE);
    @(negedge clk);

    // Cancel at iteration 10: no done, results untouched.
    launch(1'b0, 32'h0000FFFF, 32'd16);
    repeat (9) @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    check("cancel_busy", {31'd0, busy}, 32'd0);
    check("cancel_quo", quo, 32'hFFFFFFF2);
    check("cancel_rem", rem, 32'hFFFFFFFE);
    check("cancel_divzero", {31'd0, divzero}, 32'd0);
    ndone = 0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) ndone++;
    end
    check("cancel_no_done", ndone, 32'd0);

    // Simultaneous start and cancel in IDLE: start is dropped.
    start = 1'b1; cancel = 1'b1; is_signed = 1'b0; a = 32'd100; b = 32'd7;
    @(negedge clk);
    start = 1'b0; cancel = 1'b0;
    check("startcancel_busy", {31'd0, busy}, 32'd0);
    ndone = 0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) ndone++;
    end
    check("startcancel_no_done", ndone, 32'd0);

    // Reset at iteration 20 clears everything; a fresh divide still works.
    launch(1'b0, 32'd100, 32'd7);
    repeat (19) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midreset_busy", {31'd0, busy}, 32'd0);
    check("midreset_done", {31'd0, done}, 32'd0);
    check("midreset_quo", quo, 32'd0);
    check("midreset_rem", rem, 32'd0);
    check("midreset_divzero", {31'd0, divzero}, 32'd0);
    launch(1'b0, 32'd100, 32'd7);
    wait_done(lat, bcnt);
    check("post_reset_latency", lat, 32'd33);
    check("post_reset_quo", quo, 32'd14);
    check("post_reset_rem", rem, 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
